// File: rtl/fpga_frame_shifter.sv
// Framed serial link endpoint: a parallel word goes out as a framed bit stream,
// and an incoming framed bit stream is assembled back into a word.
module fpga_frame_shifter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LSB_FIRST    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  output logic             frame_out,
  input  logic             ser_in,
  input  logic             frame_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_error
);

  localparam int unsigned BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
  // The detecting edge is cycle 0 of a bit, so the counter lags the cycle index by one.
  localparam logic [CW-1:0] CLK_SAMPLE = CW'(HALF - 1);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // ---------------- transmit path ----------------
  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [BW-1:0]    r_tx_bit,   w_tx_bit_nxt;
  logic [CW-1:0]    r_tx_clk,   w_tx_clk_nxt;
  logic             r_tx_ready, w_tx_ready_nxt;
  logic             r_ser_out,  w_ser_out_nxt;
  logic             r_frame_out, w_frame_out_nxt;
  logic [WIDTH-1:0] w_tx_shifted;

  assign w_tx_shifted = LSB_FIRST ? {1'b0, r_tx_shift[WIDTH-1:1]}
                                  : {r_tx_shift[WIDTH-2:0], 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state  <= TX_IDLE;
      r_tx_shift  <= '0;
      r_tx_bit    <= '0;
      r_tx_clk    <= '0;
      r_tx_ready  <= 1'b1;
      r_ser_out   <= 1'b0;
      r_frame_out <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx_bit    <= w_tx_bit_nxt;
      r_tx_clk    <= w_tx_clk_nxt;
      r_tx_ready  <= w_tx_ready_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_frame_out <= w_frame_out_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_clk_nxt   = r_tx_clk;
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          w_tx_state_nxt = TX_SHIFT;
          w_tx_shift_nxt = tx_data;
          w_tx_bit_nxt   = '0;
          w_tx_clk_nxt   = '0;
        end
      end
      TX_SHIFT: begin
        if (r_tx_clk == CLK_LAST) begin
          w_tx_clk_nxt   = '0;
          w_tx_shift_nxt = w_tx_shifted;
          if (r_tx_bit == BIT_LAST) begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_bit_nxt   = '0;
          end else begin
            w_tx_bit_nxt = r_tx_bit + BW'(1);
          end
        end else begin
          w_tx_clk_nxt = r_tx_clk + CW'(1);
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    // Outputs are registered images of the state being entered.
    w_tx_ready_nxt  = (w_tx_state_nxt == TX_IDLE);
    w_frame_out_nxt = (w_tx_state_nxt == TX_SHIFT);
    w_ser_out_nxt   = w_frame_out_nxt & first_bit(w_tx_shift_nxt);
  end

  assign tx_ready  = r_tx_ready;
  assign ser_out   = r_ser_out;
  assign frame_out = r_frame_out;

  // ---------------- receive path ----------------
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [BW-1:0]    r_rx_bit,   w_rx_bit_nxt;
  logic [CW-1:0]    r_rx_clk,   w_rx_clk_nxt;
  logic             r_rx_armed, w_rx_armed_nxt;
  logic             r_rx_done,  w_rx_done_nxt;
  logic             r_frame_in_d;
  logic [WIDTH-1:0] r_rx_data,  w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_rx_error, w_rx_error_nxt;
  logic [WIDTH-1:0] w_rx_shift_in;
  logic             w_frame_rise;

  assign w_frame_rise  = frame_in & ~r_frame_in_d;
  assign w_rx_shift_in = LSB_FIRST ? {ser_in, r_rx_shift[WIDTH-1:1]}
                                   : {r_rx_shift[WIDTH-2:0], ser_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_shift   <= '0;
      r_rx_bit     <= '0;
      r_rx_clk     <= '0;
      r_rx_armed   <= 1'b0;
      r_rx_done    <= 1'b0;
      r_frame_in_d <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_error   <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_rx_bit     <= w_rx_bit_nxt;
      r_rx_clk     <= w_rx_clk_nxt;
      r_rx_armed   <= w_rx_armed_nxt;
      r_rx_done    <= w_rx_done_nxt;
      r_frame_in_d <= frame_in;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_error   <= w_rx_error_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_clk_nxt   = r_rx_clk;
    w_rx_armed_nxt = r_rx_armed;
    w_rx_done_nxt  = 1'b0;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_rx_error_nxt = 1'b0;
    if (r_rx_done) begin
      w_rx_data_nxt  = r_rx_shift;
      w_rx_valid_nxt = 1'b1;
    end
    case (r_rx_state)
      RX_IDLE: begin
        if (w_frame_rise) begin
          w_rx_state_nxt = RX_SHIFT;
          w_rx_shift_nxt = '0;
          w_rx_bit_nxt   = '0;
          w_rx_clk_nxt   = '0;
          w_rx_armed_nxt = 1'b0;
        end else if (r_rx_armed) begin
          // Overrun watch: frame strobe must drop within one bit after the last sample.
          if (!frame_in) begin
            w_rx_armed_nxt = 1'b0;
          end else if (r_rx_clk == CLK_LAST) begin
            w_rx_armed_nxt = 1'b0;
            w_rx_error_nxt = 1'b1;
          end else begin
            w_rx_clk_nxt = r_rx_clk + CW'(1);
          end
        end
      end
      RX_SHIFT: begin
        if (!frame_in) begin
          w_rx_state_nxt = RX_IDLE;
          w_rx_shift_nxt = '0;
          w_rx_bit_nxt   = '0;
          w_rx_clk_nxt   = '0;
          w_rx_error_nxt = 1'b1;
        end else begin
          w_rx_clk_nxt = (r_rx_clk == CLK_LAST) ? '0 : r_rx_clk + CW'(1);
          if (r_rx_clk == CLK_SAMPLE) begin
            w_rx_shift_nxt = w_rx_shift_in;
            if (r_rx_bit == BIT_LAST) begin
              w_rx_state_nxt = RX_IDLE;
              w_rx_bit_nxt   = '0;
              w_rx_clk_nxt   = '0;
              w_rx_done_nxt  = 1'b1;
              w_rx_armed_nxt = 1'b1;
            end else begin
              w_rx_bit_nxt = r_rx_bit + BW'(1);
            end
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_error = r_rx_error;

endmodule

// File: doc/fpga_frame_shifter.md
FPGA_FRAME_SHIFTER -- requirements
Module: fpga_frame_shifter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit (legal range 2..255).
REQ-003 The module SHALL have parameter LSB_FIRST, default 0: 0 = MSB shifted first, 1 = LSB shifted first.
REQ-004 The module SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port tx_data, input, WIDTH bits: the parallel word to transmit.
REQ-007 The module SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-008 The module SHALL have port tx_ready, output, 1 bit: the transmitter accepts a word this cycle.
REQ-009 The module SHALL have port ser_out, output, 1 bit: serial data to the link.
REQ-010 The module SHALL have port frame_out, output, 1 bit: high for exactly the bits of one frame.
REQ-011 The module SHALL have port ser_in, input, 1 bit: serial data from the link, already synchronised to clock.
REQ-012 The module SHALL have port frame_in, input, 1 bit: frame strobe from the link, already synchronised to clock.
REQ-013 The module SHALL have port rx_data, output, WIDTH bits: the last complete received word.
REQ-014 The module SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-015 The module SHALL have port rx_error, output, 1 bit: one-cycle pulse when a frame aborts or overruns.

Function
REQ-016 The transmit path SHALL use an FSM with two states: TX_IDLE (tx_ready=1, frame_out=0, ser_out=0) and TX_SHIFT.
REQ-017 In TX_IDLE, tx_valid=1 at a rising edge SHALL load tx_data into the shift register, clear the bit and cycle counters, and enter TX_SHIFT.
REQ-018 In TX_SHIFT, tx_ready SHALL be 0 and frame_out SHALL be 1.
REQ-019 In TX_SHIFT, ser_out SHALL present the current first bit (MSB if LSB_FIRST=0, else LSB) for exactly CLKS_PER_BIT cycles, after which the register shifts by one.
REQ-020 After WIDTH bits (WIDTH*CLKS_PER_BIT cycles in TX_SHIFT), the transmit FSM SHALL return to TX_IDLE.
REQ-021 Back-to-back frames SHALL be separated by at least one TX_IDLE cycle with frame_out=0.
REQ-022 A change of tx_data while in TX_SHIFT SHALL have no effect on the frame in flight.
REQ-023 The receive path SHALL use an FSM with two states: RX_IDLE and RX_SHIFT.
REQ-024 A rising edge of frame_in (sampled 0 then 1) SHALL move the receive FSM from RX_IDLE to RX_SHIFT and clear the bit and cycle counters.
REQ-025 In RX_SHIFT, ser_in SHALL be sampled once per bit, at cycle CLKS_PER_BIT/2 (integer division) after the bit start, and shifted in so that the word bit order matches LSB_FIRST.
REQ-026 When the WIDTH-th sample is taken, rx_data SHALL update on the following edge, rx_valid SHALL pulse for 1 cycle, and the receive FSM SHALL return to RX_IDLE.
REQ-027 If frame_in falls while in RX_SHIFT before WIDTH samples have been taken, the partial word SHALL be discarded, rx_data SHALL be kept unchanged, rx_error SHALL pulse for 1 cycle, and the receive FSM SHALL enter RX_IDLE.
REQ-028 If frame_in is still high one full bit period after the last sample, rx_error SHALL pulse for 1 cycle (overrun); the received word SHALL still be delivered.
REQ-029 The transmit and receive paths SHALL be fully independent, so that ser_out/frame_out looped back to ser_in/frame_in delivers tx_data unchanged.
REQ-030 All counters SHALL be sized for their maximum count, and no counter SHALL wrap during a legal frame.

Reset
REQ-031 reset=1 at a rising edge SHALL force both FSMs to idle and set tx_ready=1, ser_out=0, frame_out=0, rx_data=0, rx_valid=0, rx_error=0, and all counters and shift registers to 0.
REQ-032 Reset SHALL override any frame in progress; the aborted transmit frame SHALL not resume, and no rx_error SHALL be raised for it.
REQ-033 reset SHALL take priority over tx_valid and frame_in in the same cycle.

Verification
REQ-034 Scenario, default parameters, loopback: send tx_data=8'hA5 -> frame_out high for 32 cycles, ser_out = 1,0,1,0,0,1,0,1 (4 cycles each), rx_data=8'hA5 with one rx_valid pulse.
REQ-035 Scenario, LSB_FIRST=1, WIDTH=12, loopback: send 12'h3C1 -> first ser_out bit is 1, rx_data=12'h3C1.
REQ-036 Scenario, tx_valid held high for two words (8'h01, then 8'hFF): tx_ready=0 for 32 cycles, exactly one idle cycle between frames, both words received in order.
REQ-037 Scenario, frame_in driven high for 3 bits then low: rx_error pulses once, rx_valid stays 0, rx_data keeps its previous value.
REQ-038 Scenario, reset asserted during the 5th transmit bit: next cycle frame_out=0 and tx_ready=1; a new word 8'h5A then transmits and is received correctly.
REQ-039 Scenario, frame_in held high 2 bit periods beyond the 8th bit: rx_valid pulses once with the correct word, then rx_error pulses once.
